// File: rtl/wheel_period_meter.sv
// Wheel revolution period meter.
// Synchronizes a bouncy reed-switch input and counts prescaled ticks between
// debounced rising edges. Each result is offered through a valid/ready handshake.
// A period of 0 together with 'stopped' reports that no revolution arrived
// before the counter saturated.
module wheel_period_meter #(
    parameter int WIDTH    = 12,
    parameter int PRESCALE = 1000,
    parameter int DEBOUNCE = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reed,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             stopped,
    output logic             overrun
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int LW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t           state_q, state_d;
    logic             reed_meta_q, reed_meta_d;
    logic             reed_sync_q, reed_sync_d;
    logic             reed_prev_q, reed_prev_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [LW-1:0]    lock_q, lock_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             stopped_q, stopped_d;
    logic             overrun_q, overrun_d;

    logic             reed_rise;
    logic             tick;
    logic             accept;
    logic             cnt_sat;
    logic             load;
    logic [WIDTH-1:0] load_val;

    // Next-state logic: synchronizer, prescaler, lockout, FSM and output handshake
    always_comb begin
        reed_meta_d = reed;
        reed_sync_d = reed_meta_q;
        reed_prev_d = reed_sync_q;
        reed_rise   = reed_sync_q & ~reed_prev_q;

        tick    = (presc_q == PW'(PRESCALE - 1));
        accept  = reed_rise && (lock_q == '0);
        cnt_sat = (cnt_q == CNT_MAX);

        presc_d   = tick ? '0 : presc_q + PW'(1);
        lock_d    = (tick && lock_q != '0) ? lock_q - LW'(1) : lock_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = valid_q;
        stopped_d = stopped_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        load_val  = '0;

        case (state_q)
            IDLE: begin
                // Reference edge: restart the time base so the first period is tick-aligned
                if (accept) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                    presc_d = '0;
                    lock_d  = LW'(DEBOUNCE);
                end
            end
            MEASURE: begin
                if (tick && !cnt_sat) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
                if (accept) begin
                    // Include a tick landing in this same cycle so edges N ticks apart read N
                    load      = 1'b1;
                    load_val  = (tick && !cnt_sat) ? cnt_q + WIDTH'(1) : cnt_q;
                    cnt_d     = '0;
                    lock_d    = LW'(DEBOUNCE);
                    stopped_d = 1'b0;
                end else if (tick && cnt_sat) begin
                    load      = 1'b1;
                    load_val  = '0;
                    cnt_d     = '0;
                    stopped_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (valid_q && period_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            period_d = load_val;
            valid_d  = 1'b1;
            if (valid_q && !period_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            reed_meta_q <= 1'b0;
            reed_sync_q <= 1'b0;
            reed_prev_q <= 1'b0;
            presc_q     <= '0;
            lock_q      <= '0;
            cnt_q       <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            stopped_q   <= 1'b1;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            reed_meta_q <= reed_meta_d;
            reed_sync_q <= reed_sync_d;
            reed_prev_q <= reed_prev_d;
            presc_q     <= presc_d;
            lock_q      <= lock_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            stopped_q   <= stopped_d;
            overrun_q   <= overrun_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign stopped      = stopped_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_wheel_period_meter.sv
// Directed bench for wheel_period_meter with PRESCALE=4, DEBOUNCE=2, WIDTH=12.
// Reed rises are placed at absolute cycle numbers so expected periods are
// simply (cycle distance)/4.
module tb_wheel_period_meter;

    localparam int WIDTH    = 12;
    localparam int PRESCALE = 4;
    localparam int DEBOUNCE = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             reed = 1'b0;
    logic             period_ready = 1'b0;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             stopped;
    logic             overrun;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    wheel_period_meter #(
        .WIDTH(WIDTH),
        .PRESCALE(PRESCALE),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .reed(reed),
        .period(period),
        .period_valid(period_valid),
        .period_ready(period_ready),
        .stopped(stopped),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Returns at the falling edge once the posedge count has reached c
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Reed high for len cycles starting at cycle c
    task automatic pulse(input int c, input int len);
        wait_until(c);
        reed = 1'b1;
        wait_until(c + len);
        reed = 1'b0;
    endtask

    // One-cycle ready strobe; valid must drop right after it
    task automatic take(input string tag);
        @(negedge clk);
        period_ready = 1'b1;
        @(negedge clk);
        period_ready = 1'b0;
        check(tag, period_valid, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        wait_until(3);
        check("rst_period", period, 0);
        check("rst_valid", period_valid, 0);
        check("rst_stopped", stopped, 1);
        check("rst_overrun", overrun, 0);
        wait_until(5);
        rst_n = 1'b1;

        // Reference edge, then 100 ticks later, with a bounce 1 tick after it
        pulse(100, 2);
        wait_until(110);
        check("ref_valid", period_valid, 0);
        check("ref_stopped", stopped, 1);
        pulse(500, 2);
        pulse(504, 2);
        wait_until(510);
        check("p100_period", period, 100);
        check("p100_valid", period_valid, 1);
        check("p100_stopped", stopped, 0);
        take("p100_take");

        // Bounce ignored: period measured from the edge at 500
        pulse(740, 2);
        wait_until(750);
        check("bounce_period", period, 60);
        check("bounce_valid", period_valid, 1);
        take("bounce_take");

        // 50 ticks, left pending
        pulse(940, 2);
        wait_until(950);
        check("p50_period", period, 50);
        check("p50_valid", period_valid, 1);

        // Load coinciding with ready: transfer and reload, no overrun
        wait_until(1140);
        reed = 1'b1;
        wait_until(1142);
        reed = 1'b0;
        period_ready = 1'b1;
        wait_until(1143);
        period_ready = 1'b0;
        wait_until(1150);
        check("same_cyc_period", period, 50);
        check("same_cyc_valid", period_valid, 1);
        check("same_cyc_overrun", overrun, 0);

        // Load over a pending value with ready low: overrun
        pulse(1380, 2);
        wait_until(1390);
        check("ovr_period", period, 60);
        check("ovr_flag", overrun, 1);
        take("ovr_take");
        check("ovr_sticky", overrun, 1);

        // Reset 30 ticks into a measurement
        wait_until(1500);
        rst_n = 1'b0;
        #1;
        check("mid_rst_period", period, 0);
        check("mid_rst_valid", period_valid, 0);
        check("mid_rst_stopped", stopped, 1);
        check("mid_rst_overrun", overrun, 0);
        wait_until(1502);
        rst_n = 1'b1;
        pulse(1520, 2);
        wait_until(1530);
        check("post_rst_ref_valid", period_valid, 0);
        check("post_rst_ref_stopped", stopped, 1);
        pulse(1680, 2);
        wait_until(1690);
        check("p40_period", period, 40);
        check("p40_valid", period_valid, 1);
        check("p40_stopped", stopped, 0);
        take("p40_take");

        // Timeout 4096 ticks (16384 cycles) after the edge at 1680
        wait_until(1680 + 16384 - 2);
        check("pre_to_valid", period_valid, 0);
        check("pre_to_stopped", stopped, 0);
        wait_until(1680 + 16384 + 8);
        check("to_period", period, 0);
        check("to_valid", period_valid, 1);
        check("to_stopped", stopped, 1);
        take("to_take");

        // Back in IDLE: next edge is reference only
        pulse(18200, 2);
        wait_until(18210);
        check("idle_ref_valid", period_valid, 0);
        check("idle_ref_stopped", stopped, 1);

        // Edge coinciding with the saturation tick wins over timeout
        wait_until(18200 + 16384 - 2);
        check("pre_sat_valid", period_valid, 0);
        pulse(18200 + 16384, 2);
        wait_until(18200 + 16384 + 8);
        check("sat_period", period, 4095);
        check("sat_valid", period_valid, 1);
        check("sat_stopped", stopped, 0);
        take("sat_take");

        // Still measuring: next edge 100 ticks on yields a period
        pulse(18200 + 16384 + 400, 2);
        wait_until(18200 + 16384 + 410);
        check("after_sat_period", period, 100);
        check("after_sat_valid", period_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
